// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache: address field widths,
// FSM state encoding and the line-address builder.
package dcache_pkg;

   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned OFFSET_W   = 5;
   localparam int unsigned WORD_SEL_W = 3;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE      = 2'd0;
   localparam state_t ST_WRITEBACK = 2'd1;
   localparam state_t ST_ALLOCATE  = 2'd2;

   function automatic int unsigned index_w(input int unsigned lines);
      return $clog2(lines);
   endfunction

   function automatic int unsigned tag_w(input int unsigned lines);
      return ADDR_W - OFFSET_W - index_w(lines);
   endfunction

   // {tag, index, 5'b0}; tag and index arrive zero-extended to 32 bits.
   function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] tag,
                                                    input logic [ADDR_W-1:0] index,
                                                    input int unsigned       idx_w);
      return (tag << (OFFSET_W + idx_w)) | (index << OFFSET_W);
   endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Tag/valid/dirty/data arrays of the cache: combinational read by index, synchronous
// word write, line fill and valid/dirty clear on reset.
module dcache_line_store
   import dcache_pkg::*;
#(
   parameter int unsigned LINES     = 32,
   parameter int unsigned LINE_BITS = 256,
   parameter int unsigned INDEX_W   = 5,
   parameter int unsigned TAG_W     = 22
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [INDEX_W-1:0]    rd_index_i,
   output logic [TAG_W-1:0]      rd_tag_o,
   output logic                  rd_valid_o,
   output logic                  rd_dirty_o,
   output logic [LINE_BITS-1:0]  rd_line_o,
   input  logic                  word_we_i,
   input  logic [WORD_SEL_W-1:0] word_sel_i,
   input  logic [31:0]           word_data_i,
   input  logic                  fill_we_i,
   input  logic [INDEX_W-1:0]    fill_index_i,
   input  logic [TAG_W-1:0]      fill_tag_i,
   input  logic [LINE_BITS-1:0]  fill_line_i
);

   logic [TAG_W-1:0]     tag_q  [LINES];
   logic [LINE_BITS-1:0] data_q [LINES];
   logic [LINES-1:0]     valid_q;
   logic [LINES-1:0]     dirty_q;

   assign rd_tag_o   = tag_q[rd_index_i];
   assign rd_valid_o = valid_q[rd_index_i];
   assign rd_dirty_o = dirty_q[rd_index_i];
   assign rd_line_o  = data_q[rd_index_i];

   // Fill is written last so it takes precedence if both target the same line.
   always_ff @(posedge clk_i) begin
      if (word_we_i) begin
         data_q[rd_index_i][{word_sel_i, 5'b0} +: 32] <= word_data_i;
      end
      if (fill_we_i) begin
         tag_q[fill_index_i]  <= fill_tag_i;
         data_q[fill_index_i] <= fill_line_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         if (word_we_i) begin
            dirty_q[rd_index_i] <= 1'b1;
         end
         if (fill_we_i) begin
            valid_q[fill_index_i] <= 1'b1;
            dirty_q[fill_index_i] <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate L1 data cache controller: zero-latency hits,
// writeback/allocate FSM towards a multi-cycle backing memory on a miss.
module dcache_controller
   import dcache_pkg::*;
#(
   parameter int unsigned LINES     = 32,
   parameter int unsigned LINE_BITS = 256
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cpu_req_i,
   input  logic                 cpu_we_i,
   input  logic [31:0]          cpu_addr_i,
   input  logic [31:0]          cpu_wdata_i,
   output logic [31:0]          cpu_rdata_o,
   output logic                 cpu_stall_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [31:0]          mem_addr_o,
   output logic [LINE_BITS-1:0] mem_wdata_o,
   input  logic [LINE_BITS-1:0] mem_rdata_i,
   input  logic                 mem_ack_i
);

   localparam int unsigned INDEX_W = index_w(LINES);
   localparam int unsigned TAG_W   = tag_w(LINES);

   logic [WORD_SEL_W-1:0] cpu_word;
   logic [INDEX_W-1:0]    cpu_index;
   logic [TAG_W-1:0]      cpu_tag;
   logic                  unused_addr;

   assign cpu_word    = cpu_addr_i[OFFSET_W-1:2];
   assign cpu_index   = cpu_addr_i[OFFSET_W +: INDEX_W];
   assign cpu_tag     = cpu_addr_i[ADDR_W-1 -: TAG_W];
   assign unused_addr = ^cpu_addr_i[1:0];

   logic [TAG_W-1:0]     rd_tag;
   logic                 rd_valid;
   logic                 rd_dirty;
   logic [LINE_BITS-1:0] rd_line;
   logic                 hit;
   logic                 miss;
   logic                 word_we;
   logic                 fill_we;

   state_t               state_q, state_d;
   logic [TAG_W-1:0]     miss_tag_q, miss_tag_d;
   logic [INDEX_W-1:0]   miss_index_q, miss_index_d;
   logic                 mem_req_q, mem_req_d;
   logic                 mem_we_q, mem_we_d;
   logic [31:0]          mem_addr_q, mem_addr_d;
   logic [LINE_BITS-1:0] mem_wdata_q, mem_wdata_d;

   assign hit         = cpu_req_i & rd_valid & (rd_tag == cpu_tag);
   assign miss        = cpu_req_i & ~hit;
   assign cpu_stall_o = miss;
   assign cpu_rdata_o = hit ? rd_line[{cpu_word, 5'b0} +: 32] : 32'h0;
   assign word_we     = hit & cpu_we_i;
   assign fill_we     = (state_q == ST_ALLOCATE) & mem_ack_i;

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

   dcache_line_store #(
      .LINES     (LINES),
      .LINE_BITS (LINE_BITS),
      .INDEX_W   (INDEX_W),
      .TAG_W     (TAG_W)
   ) u_line_store (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .rd_index_i   (cpu_index),
      .rd_tag_o     (rd_tag),
      .rd_valid_o   (rd_valid),
      .rd_dirty_o   (rd_dirty),
      .rd_line_o    (rd_line),
      .word_we_i    (word_we),
      .word_sel_i   (cpu_word),
      .word_data_i  (cpu_wdata_i),
      .fill_we_i    (fill_we),
      .fill_index_i (miss_index_q),
      .fill_tag_i   (miss_tag_q),
      .fill_line_i  (mem_rdata_i)
   );

   // Memory-side outputs are registered so they hold steady through the ack cycle even if
   // the CPU side changes mid-miss.
   always_comb begin
      state_d      = state_q;
      miss_tag_d   = miss_tag_q;
      miss_index_d = miss_index_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (miss) begin
               miss_tag_d   = cpu_tag;
               miss_index_d = cpu_index;
               mem_req_d    = 1'b1;
               if (rd_valid && rd_dirty) begin
                  state_d     = ST_WRITEBACK;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = line_addr(32'(rd_tag), 32'(cpu_index), INDEX_W);
                  mem_wdata_d = rd_line;
               end else begin
                  state_d     = ST_ALLOCATE;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = line_addr(32'(cpu_tag), 32'(cpu_index), INDEX_W);
                  mem_wdata_d = '0;
               end
            end
         end
         ST_WRITEBACK: begin
            if (mem_ack_i) begin
               state_d     = ST_ALLOCATE;
               mem_we_d    = 1'b0;
               mem_addr_d  = line_addr(32'(miss_tag_q), 32'(miss_index_q), INDEX_W);
               mem_wdata_d = '0;
            end
         end
         ST_ALLOCATE: begin
            if (mem_ack_i) begin
               state_d    = ST_IDLE;
               mem_req_d  = 1'b0;
               mem_we_d   = 1'b0;
               mem_addr_d = '0;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         miss_tag_q   <= '0;
         miss_index_q <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         miss_tag_q   <= miss_tag_d;
         miss_index_q <= miss_index_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed scenarios plus random loads/stores
// against a line-granular cache/memory reference model and a randomly delayed responder.
module tb_dcache_controller;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         cpu_req_i;
   logic         cpu_we_i;
   logic [31:0]  cpu_addr_i;
   logic [31:0]  cpu_wdata_i;
   logic [31:0]  cpu_rdata_o;
   logic         cpu_stall_o;
   logic         mem_req_o;
   logic         mem_we_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_wdata_o;
   logic [255:0] mem_rdata_i;
   logic         mem_ack_i;

   dcache_controller #(
      .LINES     (32),
      .LINE_BITS (256)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .cpu_req_i   (cpu_req_i),
      .cpu_we_i    (cpu_we_i),
      .cpu_addr_i  (cpu_addr_i),
      .cpu_wdata_i (cpu_wdata_i),
      .cpu_rdata_o (cpu_rdata_o),
      .cpu_stall_o (cpu_stall_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .mem_ack_i   (mem_ack_i)
   );

   initial forever #5 clk_i = ~clk_i;

   int n_vec = 0;
   int n_err = 0;
   int force_delay = -1;

   typedef struct {
      bit           we;
      logic [31:0]  addr;
      logic [255:0] wdata;
      int           ncyc;
   } txn_t;

   txn_t         obs_q[$];
   logic [255:0] env_mem [logic [31:0]];
   logic [255:0] ref_mem [logic [31:0]];
   bit           m_valid [32];
   bit           m_dirty [32];
   logic [21:0]  m_tag   [32];
   logic [255:0] m_data  [32];

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] init_line(input logic [31:0] a);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) begin
         l[k*32 +: 32] = a * 32'h9E3779B1 + 32'(k) * 32'h01010101 + 32'h1234;
      end
      return l;
   endfunction

   function automatic logic [255:0] env_rd(input logic [31:0] a);
      return env_mem.exists(a) ? env_mem[a] : init_line(a);
   endfunction

   function automatic logic [255:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
   endfunction

   // Backing memory: ack after a random (or forced) number of request cycles.
   initial begin
      int           wait_cnt;
      int           ncyc;
      bit           cur_we;
      logic [31:0]  cur_addr;
      logic [255:0] cur_wd;
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
      wait_cnt    = -1;
      ncyc        = 0;
      cur_we      = 1'b0;
      cur_addr    = '0;
      cur_wd      = '0;
      forever begin
         @(negedge clk_i);
         mem_ack_i = 1'b0;
         if (rst_i) begin
            wait_cnt = -1;
         end else if (mem_req_o) begin
            if (wait_cnt < 0) begin
               wait_cnt = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
               ncyc     = 0;
               cur_we   = mem_we_o;
               cur_addr = mem_addr_o;
               cur_wd   = mem_wdata_o;
            end else begin
               check("hs_stable", 256'({mem_we_o, mem_addr_o}), 256'({cur_we, cur_addr}));
               check("hs_wdata", mem_wdata_o, cur_wd);
            end
            ncyc++;
            if (wait_cnt == 0) begin
               mem_ack_i = 1'b1;
               if (cur_we) env_mem[cur_addr] = cur_wd;
               else mem_rdata_i = env_rd(cur_addr);
               obs_q.push_back('{cur_we, cur_addr, cur_wd, ncyc});
               wait_cnt = -1;
            end else begin
               wait_cnt--;
            end
         end
      end
   end

   // One CPU access; called at posedge+1, returns at posedge+1 after completion.
   task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd);
      int           idx;
      int           wsel;
      logic [21:0]  tg;
      logic [31:0]  exp_rd;
      logic [31:0]  vaddr;
      logic [31:0]  faddr;
      txn_t         exp_q[$];
      int           stall;
      int           sum;
      bit           done;
      idx  = int'(addr[9:5]);
      tg   = addr[31:10];
      wsel = int'(addr[4:2]);
      if (!(m_valid[idx] && m_tag[idx] == tg)) begin
         if (m_valid[idx] && m_dirty[idx]) begin
            vaddr = {m_tag[idx], 5'(idx), 5'b0};
            exp_q.push_back('{1'b1, vaddr, m_data[idx], 0});
            ref_mem[vaddr] = m_data[idx];
         end
         faddr = {tg, 5'(idx), 5'b0};
         exp_q.push_back('{1'b0, faddr, 256'h0, 0});
         m_data[idx]  = ref_rd(faddr);
         m_valid[idx] = 1'b1;
         m_dirty[idx] = 1'b0;
         m_tag[idx]   = tg;
      end
      exp_rd = m_data[idx][wsel*32 +: 32];
      if (we) begin
         m_data[idx][wsel*32 +: 32] = wd;
         m_dirty[idx] = 1'b1;
      end
      cpu_req_i   = 1'b1;
      cpu_we_i    = we;
      cpu_addr_i  = addr;
      cpu_wdata_i = wd;
      stall = 0;
      done  = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk_i);
         if (cpu_stall_o) stall++;
         else done = 1'b1;
      end
      check("stall_bound", 256'(done), 256'(1));
      if (!we) check("rdata", 256'(cpu_rdata_o), 256'(exp_rd));
      @(posedge clk_i);
      #1;
      cpu_req_i = 1'b0;
      cpu_we_i  = 1'b0;
      check("txn_count", 256'(obs_q.size()), 256'(exp_q.size()));
      sum = 0;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         check("txn_we", 256'(obs_q[i].we), 256'(exp_q[i].we));
         check("txn_addr", 256'(obs_q[i].addr), 256'(exp_q[i].addr));
         if (exp_q[i].we) check("txn_wdata", obs_q[i].wdata, exp_q[i].wdata);
         sum += obs_q[i].ncyc;
      end
      check("stall_cycles", 256'(stall), 256'((exp_q.size() == 0) ? 0 : sum + 1));
      check("req_idle", 256'(mem_req_o), 256'(0));
      obs_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit seen;
      rst_i       = 1'b1;
      cpu_req_i   = 1'b0;
      cpu_we_i    = 1'b0;
      cpu_addr_i  = '0;
      cpu_wdata_i = '0;
      for (int i = 0; i < 32; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
         m_tag[i]   = '0;
         m_data[i]  = '0;
      end
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      check("rst_stall", 256'(cpu_stall_o), 256'(0));
      check("rst_rdata", 256'(cpu_rdata_o), 256'(0));
      check("rst_mem_req", 256'(mem_req_o), 256'(0));
      check("rst_mem_we", 256'(mem_we_o), 256'(0));
      check("rst_mem_addr", 256'(mem_addr_o), 256'(0));
      check("rst_mem_wdata", mem_wdata_o, 256'(0));

      // Directed scenarios: ack three request cycles in for the first fill.
      force_delay = 2;
      access(1'b0, 32'h0000_0404, 32'h0);
      force_delay = -1;
      access(1'b0, 32'h0000_0404, 32'h0);
      access(1'b1, 32'h0000_0404, 32'hDEAD_BEEF);
      access(1'b0, 32'h0000_0404, 32'h0);
      access(1'b0, 32'h0000_0004, 32'h0);
      access(1'b1, 32'h0000_0820, 32'h1357_9BDF);
      access(1'b0, 32'h0000_0820, 32'h0);
      access(1'b0, 32'h0000_083C, 32'h0);

      // Random loads/stores over a few tags and indices to force conflicts and writebacks.
      for (int n = 0; n < 300; n++) begin
         logic [31:0] a;
         a = {20'($urandom_range(0, 3)), 2'b00, 5'($urandom_range(0, 3)),
              3'($urandom_range(0, 7)), 2'b00};
         access(1'($urandom_range(0, 1)), a, $urandom);
      end

      // Reset while a writeback is outstanding.
      access(1'b1, 32'h0000_1044, 32'hCAFE_F00D);
      force_delay = 50;
      cpu_req_i   = 1'b1;
      cpu_we_i    = 1'b0;
      cpu_addr_i  = 32'h0000_0C44;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk_i);
         if (mem_req_o && mem_we_o) seen = 1'b1;
      end
      check("wb_started", 256'(seen), 256'(1));
      @(posedge clk_i);
      #1;
      rst_i     = 1'b1;
      cpu_req_i = 1'b0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      check("rst_mid_req", 256'(mem_req_o), 256'(0));
      check("rst_mid_we", 256'(mem_we_o), 256'(0));
      check("rst_mid_stall", 256'(cpu_stall_o), 256'(0));
      obs_q.delete();
      force_delay = -1;
      for (int i = 0; i < 32; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      access(1'b0, 32'h0000_1044, 32'h0);
      access(1'b0, 32'h0000_0820, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache controller between the MEM stage (Data_Memory port) and a slow multi-cycle backing memory.
- Holds the line store and tag/valid/dirty state, and serves hits in the same cycle.
- On a miss it runs a writeback/allocate FSM and asserts cpu_stall_o, which the pipeline uses to freeze PC, IF_ID, ID_EX, EX_MEM and MEM_WB.

Parameters:
- LINES, 32, number of cache lines (power of 2); INDEX_W = log2(LINES).
- LINE_BITS, 256, line size in bits (8 words); offset field is 5 bits.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cpu_req_i  in  1  MEM stage access valid (MemRead|MemWrite)
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address (word aligned)
- cpu_wdata_i  in  32  store data
- cpu_rdata_o  out  32  load data
- cpu_stall_o  out  1  freeze pipeline
- mem_req_o  out  1  backing memory request
- mem_we_o  out  1  1 = line write, 0 = line read
- mem_addr_o  out  32  line address, bits [4:0] = 0
- mem_wdata_o  out  LINE_BITS  writeback line
- mem_rdata_i  in  LINE_BITS  fill line
- mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Address split: word = addr[4:2], index = addr[5+INDEX_W-1:5], tag = addr[31:5+INDEX_W] (22 bits at default).
- Reset:
  - all valid and dirty bits cleared; state = IDLE.
  - mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
  - cpu_stall_o = 0, cpu_rdata_o = 0.
  - Tag and data contents are don't-care.
- hit = cpu_req_i & valid[index] & (tag_store[index] == tag).
- Output timing: tag/valid/data reads are combinational; cpu_stall_o = cpu_req_i & ~hit, asserted in any state, same cycle.
- Read hit (IDLE): cpu_rdata_o = selected word, combinational, zero-latency; no stall.
- Write hit (IDLE): at posedge, the selected word is replaced with cpu_wdata_i and dirty[index] is set; no stall.
- cpu_rdata_o = 0 whenever cpu_req_i = 0 or on a miss.
- States:
  - IDLE: on a miss, go to WRITEBACK if valid & dirty of the victim line, else ALLOCATE.
  - WRITEBACK:
    - Outputs: mem_req_o = 1, mem_we_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_wdata_o = victim line.
    - On mem_ack_i: go to ALLOCATE.
  - ALLOCATE:
    - Outputs: mem_req_o = 1, mem_we_o = 0, mem_addr_o = {tag, index, 5'b0}.
    - On mem_ack_i: line = mem_rdata_i, tag stored, valid = 1, dirty = 0; go to IDLE.
    - The access then hits in IDLE the next cycle; a store merges at that point.
- Handshake: mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o stay stable from request assertion through the ack cycle. mem_req_o is never low between WRITEBACK and ALLOCATE. mem_ack_i is ignored when mem_req_o = 0.
- Latency: clean miss = N+1 stall cycles, where N = cycles from request to ack inclusive. Dirty miss = Nwb + Nfill + 1.
- CPU inputs are held stable by the pipeline while cpu_stall_o = 1. If cpu_req_i drops mid-miss, the current transaction still completes (no abort), then the FSM returns to IDLE.
- Reset mid-operation: the transaction is abandoned and mem_req_o = 0 from the reset cycle's edge. Dirty data is lost, which is acceptable.
- Ack in the same cycle as reset: reset wins.

Decomposition:
- Shared package dcache_pkg holds:
  - state enum {IDLE, WRITEBACK, ALLOCATE};
  - OFFSET_W = 5, WORD_SEL_W = 3, and derived TAG_W / INDEX_W functions;
  - line-address build helper.
- One sub-module, dcache_line_store:
  - Contents: tag, valid, dirty and data arrays.
  - Reads: combinational, by index.
  - Writes: synchronous, covering word write, line fill and valid/dirty clear on rst_i.
- The controller holds the FSM and hit logic.

Test Plan:
- Post-reset read 0x0000_0404, memory acks 3 cycles after request -> cpu_stall_o high 4 cycles; single ALLOCATE with mem_addr_o = 0x0000_0400; cpu_rdata_o = word 1 of fill line.
- Repeat read 0x0000_0404 -> no stall, same data in the same cycle, mem_req_o stays 0.
- Write 0xDEADBEEF to 0x0000_0404 (hit) -> no stall; dirty[0] = 1; subsequent read returns 0xDEADBEEF.
- Read 0x0000_0004 (index 0, tag 0, conflicts with tag 1):
  - WRITEBACK first, mem_we_o = 1, mem_addr_o = 0x0000_0400, mem_wdata_o word 1 = 0xDEADBEEF;
  - then ALLOCATE at 0x0000_0000 with mem_req_o continuous;
  - stall ends one cycle after the fill ack.
- Write miss to clean line 0x0000_0820 -> ALLOCATE at 0x0000_0820; merged word 0 = store data; dirty set; other 7 words = fill data.
- rst_i pulsed during WRITEBACK -> mem_req_o = 0 next cycle, state IDLE; a later read of a previously valid address misses.
